// File: rtl/systolic_skew_feeder_if.sv
// Beat-side handshake and MMU-facing lanes of systolic_skew_feeder.
// Stall_Cnt is present only when STALL_COUNT_EN is defined.
interface systolic_skew_feeder_if #(
    parameter int WIDTH  = 8,
    parameter int LENGTH = 3
);
    logic                          In_Valid;
    logic                          In_Ready;
    logic [LENGTH-1:0][WIDTH-1:0]  In_A;
    logic [LENGTH-1:0][WIDTH-1:0]  In_B;
    logic [LENGTH-1:0][WIDTH-1:0]  Mmu_Inputs;
    logic [LENGTH-1:0][WIDTH-1:0]  Mmu_Weights;
    logic                          Mmu_En;
    logic                          Mmu_Clr;
    logic                          Result_Valid;
    logic                          Result_Ack;
    logic                          Busy;
`ifdef STALL_COUNT_EN
    logic [15:0]                   Stall_Cnt;

    modport master (
        output In_Valid, In_A, In_B, Result_Ack,
        input  In_Ready, Mmu_Inputs, Mmu_Weights, Mmu_En, Mmu_Clr,
               Result_Valid, Busy, Stall_Cnt
    );
    modport slave (
        input  In_Valid, In_A, In_B, Result_Ack,
        output In_Ready, Mmu_Inputs, Mmu_Weights, Mmu_En, Mmu_Clr,
               Result_Valid, Busy, Stall_Cnt
    );
`else
    modport master (
        output In_Valid, In_A, In_B, Result_Ack,
        input  In_Ready, Mmu_Inputs, Mmu_Weights, Mmu_En, Mmu_Clr,
               Result_Valid, Busy
    );
    modport slave (
        input  In_Valid, In_A, In_B, Result_Ack,
        output In_Ready, Mmu_Inputs, Mmu_Weights, Mmu_En, Mmu_Clr,
               Result_Valid, Busy
    );
`endif
endinterface

// File: rtl/systolic_skew_feeder.sv
// Skews one LENGTH-beat tile into the MMU lanes, sequences EN/clear and flags the final result.
// Optional STALL_COUNT_EN macro adds a saturating count of starved LOAD cycles (Stall_Cnt).
module systolic_skew_feeder #(
    parameter int WIDTH      = 8,
    parameter int LENGTH     = 3,
    parameter int PIPE_SLACK = 1
) (
    input  logic                 CLK,
    input  logic                 ASYNC_RST,
    input  logic                 SYNC_RST,
    systolic_skew_feeder_if.slave bus
);
    localparam int CW        = $clog2(2 * LENGTH + PIPE_SLACK) + 1;
    localparam int DRAIN_LEN = 2 * LENGTH - 1 + PIPE_SLACK;

    localparam logic [CW-1:0] LAST_BEAT  = CW'(LENGTH - 1);
    localparam logic [CW-1:0] LAST_DRAIN = CW'(DRAIN_LEN - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   beat_cnt;
    logic [CW-1:0]   drain_cnt;
    logic            mmu_en;
    logic            mmu_clr;
    logic            result_valid;
    logic            ready;
    logic            take;
    logic            shift;

    assign ready = (state == IDLE) || (state == LOAD);
    assign take  = ready && bus.In_Valid;
    // Lanes and array advance together; a starved LOAD cycle freezes both.
    assign shift = take || (state == DRAIN);

    assign bus.In_Ready     = ready;
    assign bus.Busy         = (state != IDLE);
    assign bus.Mmu_En       = mmu_en;
    assign bus.Mmu_Clr      = mmu_clr;
    assign bus.Result_Valid = result_valid;

`ifdef STALL_COUNT_EN
    logic [15:0] stall_cnt;
    assign bus.Stall_Cnt = stall_cnt;
`endif

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            drain_cnt    <= '0;
            mmu_en       <= 1'b0;
            mmu_clr      <= 1'b0;
            result_valid <= 1'b0;
`ifdef STALL_COUNT_EN
            stall_cnt    <= '0;
`endif
        end else if (SYNC_RST) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            drain_cnt    <= '0;
            mmu_en       <= 1'b0;
            mmu_clr      <= 1'b0;
            result_valid <= 1'b0;
`ifdef STALL_COUNT_EN
            stall_cnt    <= '0;
`endif
        end else begin
            mmu_clr <= 1'b0;
            mmu_en  <= shift;
`ifdef STALL_COUNT_EN
            if (state == LOAD && !bus.In_Valid && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
`endif
            case (state)
                IDLE: begin
                    if (bus.In_Valid) begin
                        beat_cnt  <= CW'(1);
                        drain_cnt <= '0;
                        state     <= (LENGTH == 1) ? DRAIN : LOAD;
                    end
                end
                LOAD: begin
                    if (bus.In_Valid) begin
                        beat_cnt <= beat_cnt + CW'(1);
                        if (beat_cnt == LAST_BEAT)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == LAST_DRAIN) begin
                        state        <= DONE;
                        result_valid <= 1'b1;
                        // The final zero-flush step is not needed; keep the array idle in DONE.
                        mmu_en       <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.Result_Ack) begin
                        state        <= IDLE;
                        result_valid <= 1'b0;
                        mmu_clr      <= 1'b1;
                        beat_cnt     <= '0;
                        drain_cnt    <= '0;
`ifdef STALL_COUNT_EN
                        stall_cnt    <= '0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Lane r is a chain of r+1 registers; its last stage drives the MMU directly.
    for (genvar r = 0; r < LENGTH; r++) begin : g_lane
        logic [WIDTH-1:0] a_sr [0:r];
        logic [WIDTH-1:0] b_sr [0:r];

        always_ff @(posedge CLK or negedge ASYNC_RST) begin
            if (!ASYNC_RST) begin
                for (int j = 0; j <= r; j++) begin
                    a_sr[j] <= '0;
                    b_sr[j] <= '0;
                end
            end else if (SYNC_RST) begin
                for (int j = 0; j <= r; j++) begin
                    a_sr[j] <= '0;
                    b_sr[j] <= '0;
                end
            end else if (shift) begin
                a_sr[0] <= take ? bus.In_A[r] : '0;
                b_sr[0] <= take ? bus.In_B[r] : '0;
                for (int j = 1; j <= r; j++) begin
                    a_sr[j] <= a_sr[j-1];
                    b_sr[j] <= b_sr[j-1];
                end
            end
        end

        assign bus.Mmu_Inputs[r]  = a_sr[r];
        assign bus.Mmu_Weights[r] = b_sr[r];
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder (WIDTH=8, LENGTH=3, PIPE_SLACK=1)
// with a small output-stationary MMU model attached to the lanes.
module tb_systolic_skew_feeder;
    logic clk;
    logic rst_n;
    logic sync_rst;

    int checks;
    int failures;

    systolic_skew_feeder_if #(.WIDTH(8), .LENGTH(3)) bus ();

    systolic_skew_feeder #(.WIDTH(8), .LENGTH(3), .PIPE_SLACK(1)) dut (
        .CLK       (clk),
        .ASYNC_RST (rst_n),
        .SYNC_RST  (sync_rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [2:0][7:0] lanes_t;

    typedef struct {
        logic   valid;
        lanes_t a;
        lanes_t b;
        lanes_t exp_in;
        lanes_t exp_w;
        logic   exp_en;
        logic   exp_rv;
        logic   exp_rdy;
    } vec_t;

    int mat_a [3][3] = '{'{4, 3, 7}, '{4, 4, 7}, '{6, 8, 2}};
    int mat_b [3][3] = '{'{9, 4, 5}, '{10, 4, 5}, '{7, 4, 7}};
    int exp_c [3][3] = '{'{115, 56, 84}, '{125, 60, 89}, '{148, 64, 84}};
    int ident [3][3] = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 1}};

    // Output-stationary array: A moves right, B moves down, each PE accumulates.
    int acc [3][3];
    int ar  [3][3];
    int br  [3][3];

    function automatic int a_in(int i, int j);
        return (j == 0) ? int'(bus.Mmu_Inputs[i]) : ar[i][j-1];
    endfunction

    function automatic int b_in(int i, int j);
        return (i == 0) ? int'(bus.Mmu_Weights[j]) : br[i-1][j];
    endfunction

    always @(posedge clk) begin
        if (!rst_n || sync_rst || bus.Mmu_Clr) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) begin
                    acc[i][j] <= 0;
                    ar[i][j]  <= 0;
                    br[i][j]  <= 0;
                end
        end else if (bus.Mmu_En) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) begin
                    acc[i][j] <= acc[i][j] + a_in(i, j) * b_in(i, j);
                    ar[i][j]  <= a_in(i, j);
                    br[i][j]  <= b_in(i, j);
                end
        end
    end

    function automatic lanes_t pack3(input int e0, input int e1, input int e2);
        lanes_t v;
        v[0] = 8'(e0);
        v[1] = 8'(e1);
        v[2] = 8'(e2);
        return v;
    endfunction

    function automatic vec_t mk_vec(input logic v, input lanes_t a, input lanes_t b,
                                    input lanes_t ei, input lanes_t ew,
                                    input logic en, input logic rv, input logic rdy);
        vec_t x;
        x.valid = v;   x.a = a;        x.b = b;
        x.exp_in = ei; x.exp_w = ew;
        x.exp_en = en; x.exp_rv = rv;  x.exp_rdy = rdy;
        return x;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input lanes_t a, input lanes_t b);
        bus.In_Valid = valid;
        bus.In_A     = a;
        bus.In_B     = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int  obs_ticks;
    int  obs_latency;
    int  obs_en_low;
    bit  obs_active;

    task automatic stepObserve();
        tick();
        if (obs_active) begin
            obs_ticks++;
            if (obs_latency < 0) begin
                if (bus.Result_Valid) obs_latency = obs_ticks;
                else if (!bus.Mmu_En) obs_en_low++;
            end
        end
    endtask

    task automatic checkResult(input string tag, input int m [3][3]);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                checkOutput($sformatf("%s_c%0d%0d", tag, i, j), acc[i][j], m[i][j]);
    endtask

    // Beats 0..2 with an optional starved gap (Result_Ack pulsed, must be ignored).
    task automatic runTile(input int ma [3][3], input int mb [3][3], input int stall_after,
                           input int stall_len, output int latency, output int en_low);
        lanes_t a;
        lanes_t b;
        obs_active  = 0;
        obs_ticks   = 0;
        obs_latency = -1;
        obs_en_low  = 0;
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 3; r++) begin
                a[r] = 8'(ma[r][k]);
                b[r] = 8'(mb[k][r]);
            end
            applyStimulus(1'b1, a, b);
            if (k == 0) begin
                tick();
                checkOutput("clr_pulse_end", bus.Mmu_Clr, 1'b0);
                checkOutput("busy_after_start", bus.Busy, 1'b1);
                obs_active = 1;
            end else begin
                stepObserve();
            end
            if (k == stall_after) begin
                for (int s = 0; s < stall_len; s++) begin
                    applyStimulus(1'b0, a, b);
                    bus.Result_Ack = 1'b1;
                    stepObserve();
                    bus.Result_Ack = 1'b0;
                end
            end
        end
        applyStimulus(1'b0, '0, '0);
        for (int t = 0; t < 40 && obs_latency < 0; t++)
            stepObserve();
        if (obs_latency < 0)
            checkOutput("rv_timeout", 32'd0, 32'd1);
        latency = obs_latency;
        en_low  = obs_en_low;
    endtask

    task automatic ackTile();
        bus.Result_Ack = 1'b1;
        tick();
        bus.Result_Ack = 1'b0;
        checkOutput("ack_clr_pulse", bus.Mmu_Clr, 1'b1);
        checkOutput("ack_rv_drop", bus.Result_Valid, 1'b0);
        checkOutput("ack_ready", bus.In_Ready, 1'b1);
        checkOutput("ack_busy", bus.Busy, 1'b0);
    endtask

    vec_t tbl [9];
    int   lat;
    int   enl;
    int   rv_seen;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;

        tbl[0] = mk_vec(1'b1, pack3(4, 4, 6),  pack3(9, 4, 5),  pack3(4, 0, 0), pack3(9, 0, 0),  1'b1, 1'b0, 1'b1);
        tbl[1] = mk_vec(1'b1, pack3(3, 4, 8),  pack3(10, 4, 5), pack3(3, 4, 0), pack3(10, 4, 0), 1'b1, 1'b0, 1'b1);
        tbl[2] = mk_vec(1'b1, pack3(7, 7, 2),  pack3(7, 4, 7),  pack3(7, 4, 6), pack3(7, 4, 5),  1'b1, 1'b0, 1'b0);
        tbl[3] = mk_vec(1'b0, '0, '0, pack3(0, 7, 8), pack3(0, 4, 5), 1'b1, 1'b0, 1'b0);
        tbl[4] = mk_vec(1'b0, '0, '0, pack3(0, 0, 2), pack3(0, 0, 7), 1'b1, 1'b0, 1'b0);
        tbl[5] = mk_vec(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        tbl[6] = mk_vec(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        tbl[7] = mk_vec(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        tbl[8] = mk_vec(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);

        rst_n          = 1'b0;
        sync_rst       = 1'b0;
        bus.Result_Ack = 1'b0;
        applyStimulus(1'b0, '0, '0);
        #1;
        checkOutput("rst_inputs", bus.Mmu_Inputs, 24'h0);
        checkOutput("rst_weights", bus.Mmu_Weights, 24'h0);
        checkOutput("rst_en", bus.Mmu_En, 1'b0);
        checkOutput("rst_clr", bus.Mmu_Clr, 1'b0);
        checkOutput("rst_rv", bus.Result_Valid, 1'b0);
        checkOutput("rst_busy", bus.Busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_ready", bus.In_Ready, 1'b1);
        checkOutput("post_rst_busy", bus.Busy, 1'b0);

        $display("[TB] skew table, tile A*B");
        for (int n = 0; n < 9; n++) begin
            applyStimulus(tbl[n].valid, tbl[n].a, tbl[n].b);
            tick();
            checkOutput($sformatf("skew%0d_inputs", n), bus.Mmu_Inputs, tbl[n].exp_in);
            checkOutput($sformatf("skew%0d_weights", n), bus.Mmu_Weights, tbl[n].exp_w);
            checkOutput($sformatf("skew%0d_en", n), bus.Mmu_En, tbl[n].exp_en);
            checkOutput($sformatf("skew%0d_rv", n), bus.Result_Valid, tbl[n].exp_rv);
            checkOutput($sformatf("skew%0d_ready", n), bus.In_Ready, tbl[n].exp_rdy);
        end
        checkResult("tile1", exp_c);
        tick();
        checkOutput("done_hold_rv", bus.Result_Valid, 1'b1);
        checkOutput("done_hold_en", bus.Mmu_En, 1'b0);

        $display("[TB] back-to-back identity tile");
        ackTile();
        runTile(ident, ident, -1, 0, lat, enl);
        checkOutput("ident_latency", lat, 8);
        checkOutput("ident_en_low", enl, 0);
        checkResult("ident", ident);

        $display("[TB] starved tile");
        ackTile();
        runTile(mat_a, mat_b, 1, 2, lat, enl);
        checkOutput("stall_latency", lat, 10);
        checkOutput("stall_en_low", enl, 2);
        checkResult("stall", exp_c);
`ifdef STALL_COUNT_EN
        checkOutput("stall_cnt", bus.Stall_Cnt, 16'd2);
`endif
        ackTile();
`ifdef STALL_COUNT_EN
        checkOutput("stall_cnt_cleared", bus.Stall_Cnt, 16'd0);
`endif
        tick();
        checkOutput("clr_single_cycle", bus.Mmu_Clr, 1'b0);

        $display("[TB] abort during drain");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, pack3(mat_a[0][k], mat_a[1][k], mat_a[2][k]), pack3(mat_b[k][0], mat_b[k][1], mat_b[k][2]));
            tick();
        end
        applyStimulus(1'b0, '0, '0);
        repeat (2) tick();
        sync_rst = 1'b1;
        tick();
        sync_rst = 1'b0;
        checkOutput("abort_busy", bus.Busy, 1'b0);
        checkOutput("abort_ready", bus.In_Ready, 1'b1);
        checkOutput("abort_inputs", bus.Mmu_Inputs, 24'h0);
        checkOutput("abort_weights", bus.Mmu_Weights, 24'h0);
        checkOutput("abort_en", bus.Mmu_En, 1'b0);
        rv_seen = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (bus.Result_Valid) rv_seen++;
        end
        checkOutput("abort_no_rv", rv_seen, 0);
        runTile(mat_a, mat_b, -1, 0, lat, enl);
        checkOutput("after_abort_latency", lat, 8);
        checkResult("after_abort", exp_c);
        ackTile();

        $display("[TB] async reset mid-tile");
        applyStimulus(1'b1, pack3(4, 4, 6), pack3(9, 4, 5));
        tick();
        checkOutput("pre_async_busy", bus.Busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_inputs", bus.Mmu_Inputs, 24'h0);
        checkOutput("async_weights", bus.Mmu_Weights, 24'h0);
        checkOutput("async_en", bus.Mmu_En, 1'b0);
        checkOutput("async_busy", bus.Busy, 1'b0);
        checkOutput("async_rv", bus.Result_Valid, 1'b0);
        applyStimulus(1'b0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("async_release_ready", bus.In_Ready, 1'b1);
        checkOutput("async_release_busy", bus.Busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
